// File: rtl/song_sequencer_pkg.sv
// Shared widths, note-word layout and sequencer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package song_sequencer_pkg;

    localparam int OCTAVE_BITS    = 3;
    localparam int NOTE_BITS      = 3;
    localparam int LENGTH_BITS    = 3;
    localparam int FULL_NOTE_BITS = 4;
    localparam int WORD_W         = 16;

    // Note code that means "silence for this duration".
    localparam logic [NOTE_BITS-1:0] REST_NOTE = 3'd7;

    // ROM word: [15] end marker, [14:12] octave, [11:9] note, [8:6] length, [5:0] reserved.
    typedef struct packed {
        logic                   end_mark;
        logic [OCTAVE_BITS-1:0] octave;
        logic [NOTE_BITS-1:0]   note;
        logic [LENGTH_BITS-1:0] length;
        logic [5:0]             rsvd;
    } note_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ARM,
        ST_PLAY,
        ST_GAP,
        ST_PAUSED,
        ST_DONE
    } seq_state_t;

    // States in which a song is actively being walked through.
    function automatic logic is_active(input seq_state_t s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_ARM) ||
               (s == ST_PLAY)  || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/song_sequencer.sv
// Walks a song in ROM and drives the tone generator note by note, with a silent gap between notes.
// Latency: all outputs registered; one ROM read per note, 2-cycle arm, GAP_CYCLES of silence after over.
// Backpressure: waits on the generator's over flag; play/pause/stop pulses steer the walk.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int GAP_CYCLES  = 5_000_000,
    parameter int SONG_BASE_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      play,
    input  logic                      pause,
    input  logic                      stop,
    input  logic                      loop,
    input  logic [SONG_BASE_W-1:0]    song_sel,
    input  logic [FULL_NOTE_BITS-1:0] tempo,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [WORD_W-1:0]         rom_data,
    output logic                      snd_en,
    output logic [OCTAVE_BITS-1:0]    snd_octave,
    output logic [NOTE_BITS-1:0]      snd_note,
    output logic [LENGTH_BITS-1:0]    snd_length,
    output logic [FULL_NOTE_BITS-1:0] snd_full_note,
    input  logic                      snd_over,
    output logic                      snd_mute,
    output logic                      playing,
    output logic                      paused,
    output logic                      done
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    seq_state_t state, state_nxt;
    note_word_t word;
    logic [SONG_BASE_W-1:0] song_q;
    logic                   arm_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   rest_q;
    logic                   start, restart, advance;
    logic                   unused_rsvd;

    logic                   en_nxt, mute_nxt, rest_nxt;
    logic                   playing_nxt, paused_nxt, done_nxt;
    logic [OCTAVE_BITS-1:0] octave_nxt;
    logic [NOTE_BITS-1:0]   note_nxt;
    logic [LENGTH_BITS-1:0] length_nxt;

    assign word        = note_word_t'(rom_data);
    assign unused_rsvd = ^word.rsvd;

    assign start   = ((state == ST_IDLE) || (state == ST_DONE)) && (state_nxt == ST_FETCH);
    assign restart = (state == ST_DECODE) && (state_nxt == ST_FETCH);
    assign advance = (state == ST_PLAY) && (state_nxt == ST_GAP);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state: stop beats pause beats play; pause only bites while a song is active.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else if (pause && is_active(state)) begin
            state_nxt = ST_PAUSED;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_PAUSED: if (play) state_nxt = ST_FETCH;
                ST_FETCH:  state_nxt = ST_DECODE;
                ST_DECODE: begin
                    if (word.end_mark) state_nxt = loop ? ST_FETCH : ST_DONE;
                    else               state_nxt = ST_ARM;
                end
                // The generator's over flag is stale until it has seen en, so ARM ignores it.
                ST_ARM:  if (arm_cnt)           state_nxt = ST_PLAY;
                ST_PLAY: if (snd_over)          state_nxt = ST_GAP;
                ST_GAP:  if (gap_cnt == '0)     state_nxt = ST_FETCH;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Next output values, derived from the state being entered so outputs line up with it.
    always_comb begin
        octave_nxt = snd_octave;
        note_nxt   = snd_note;
        length_nxt = snd_length;
        rest_nxt   = rest_q;
        if ((state == ST_DECODE) && (state_nxt == ST_ARM)) begin
            octave_nxt = word.octave;
            rest_nxt   = (word.note == REST_NOTE);
            note_nxt   = rest_nxt ? '0 : word.note;
            length_nxt = word.length;
        end
        en_nxt      = (state_nxt == ST_ARM) || (state_nxt == ST_PLAY);
        mute_nxt    = en_nxt ? rest_nxt : 1'b1;
        playing_nxt = is_active(state_nxt);
        paused_nxt  = (state_nxt == ST_PAUSED);
        done_nxt    = (state_nxt == ST_DONE);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            snd_en     <= 1'b0;
            snd_mute   <= 1'b1;
            snd_octave <= '0;
            snd_note   <= '0;
            snd_length <= '0;
            rest_q     <= 1'b0;
            playing    <= 1'b0;
            paused     <= 1'b0;
            done       <= 1'b0;
        end else begin
            snd_en     <= en_nxt;
            snd_mute   <= mute_nxt;
            snd_octave <= octave_nxt;
            snd_note   <= note_nxt;
            snd_length <= length_nxt;
            rest_q     <= rest_nxt;
            playing    <= playing_nxt;
            paused     <= paused_nxt;
            done       <= done_nxt;
        end
    end

    // Song address, latched song/tempo, arm and gap timers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr      <= '0;
            song_q        <= '0;
            snd_full_note <= '0;
            arm_cnt       <= 1'b0;
            gap_cnt       <= '0;
        end else begin
            arm_cnt <= (state == ST_ARM) && !arm_cnt;
            if (start) begin
                song_q        <= song_sel;
                snd_full_note <= tempo;
                rom_addr      <= {song_sel, {(ADDR_W-SONG_BASE_W){1'b0}}};
            end else if (restart) begin
                rom_addr <= {song_q, {(ADDR_W-SONG_BASE_W){1'b0}}};
            end else if (advance) begin
                rom_addr <= rom_addr + 1'b1;
            end
            if (advance)
                gap_cnt <= GAP_LOAD;
            else if ((state == ST_GAP) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: ROM and tone generator models, abstract per-cycle model, directed scenarios.
// Latency: compares every cycle on the falling edge once reset has been seen.
// Backpressure: generator model holds over low for gen_n cycles after seeing en.
module tb_song_sequencer;

    localparam int GAP = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play = 1'b0, pause = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [1:0]  song_sel = 2'd0;
    logic [3:0]  tempo = 4'd5;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = 16'h0;
    logic        snd_en, snd_mute, snd_over;
    logic [2:0]  snd_octave, snd_note, snd_length;
    logic [3:0]  snd_full_note;
    logic        playing, paused, done;

    logic [15:0] rom [256];
    int gcnt = 0;
    int gen_n = 3;
    int gen_hold = 1;

    int n_checks = 0;
    int n_err = 0;

    // Model state: what the sequencer should be doing, in terms of note age rather than FSM states.
    int m_ok = 0, m_mode = M_IDLE, m_addr = 0, m_base = 0, m_age = 0, m_in_gap = 0, m_gap = 0;
    int m_oct = 0, m_note = 0, m_len = 0, m_full = 0, m_rest = 0;

    song_sequencer #(.ADDR_W(8), .GAP_CYCLES(GAP), .SONG_BASE_W(2)) dut (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop), .loop(loop),
        .song_sel(song_sel), .tempo(tempo), .rom_addr(rom_addr), .rom_data(rom_data),
        .snd_en(snd_en), .snd_octave(snd_octave), .snd_note(snd_note), .snd_length(snd_length),
        .snd_full_note(snd_full_note), .snd_over(snd_over), .snd_mute(snd_mute),
        .playing(playing), .paused(paused), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Tone generator: counts enabled cycles; over is stale-high for gen_hold cycles, then low until gen_n passes.
    always @(posedge clk) begin
        if (!snd_en)          gcnt <= 0;
        else if (gcnt < 1000) gcnt <= gcnt + 1;
    end
    assign snd_over = !snd_en || (gcnt < gen_hold) || (gcnt > gen_n);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    // Note age: 0 fetch, 1 read word, 2-3 arm, 4+ sounding until over; then GAP silent cycles.
    task automatic model_step();
        logic [15:0] w;
        if (rst) begin
            m_ok = 1; m_mode = M_IDLE; m_addr = 0; m_age = 0; m_in_gap = 0; m_gap = 0;
            m_oct = 0; m_note = 0; m_len = 0; m_full = 0; m_rest = 0;
        end else if (stop) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_RUN && pause) begin
            m_mode = M_PAUSE;
        end else if (play && (m_mode == M_IDLE || m_mode == M_DONE)) begin
            m_base = int'(song_sel) * 64; m_addr = m_base; m_full = int'(tempo);
            m_mode = M_RUN; m_age = 0; m_in_gap = 0;
        end else if (play && m_mode == M_PAUSE) begin
            m_mode = M_RUN; m_age = 0; m_in_gap = 0;
        end else if (m_mode == M_RUN) begin
            if (m_in_gap != 0) begin
                if (m_gap == GAP - 1) begin m_in_gap = 0; m_age = 0; end
                else m_gap++;
            end else if (m_age == 1) begin
                w = rom[m_addr];
                if (w[15]) begin
                    if (loop) begin m_addr = m_base; m_age = 0; end
                    else m_mode = M_DONE;
                end else begin
                    m_oct = int'(w[14:12]); m_len = int'(w[8:6]);
                    m_rest = (w[11:9] == 3'd7) ? 1 : 0;
                    m_note = (m_rest != 0) ? 0 : int'(w[11:9]);
                    m_age = 2;
                end
            end else if (m_age >= 4 && snd_over) begin
                m_in_gap = 1; m_gap = 0; m_addr = (m_addr + 1) % 256;
            end else begin
                m_age++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        logic [25:0] dv, ev;
        logic en_e;
        @(negedge clk);
        if (m_ok != 0) begin
            en_e = (m_mode == M_RUN) && (m_in_gap == 0) && (m_age >= 2);
            dv = {rom_addr, snd_en, snd_octave, snd_note, snd_length, snd_full_note,
                  snd_mute, playing, paused, done};
            ev = {8'(m_addr), en_e, 3'(m_oct), 3'(m_note), 3'(m_len), 4'(m_full),
                  (!en_e || m_rest != 0), (m_mode == M_RUN), (m_mode == M_PAUSE), (m_mode == M_DONE)};
            n_checks++;
            if (dv !== ev) begin
                n_err++;
                $display("FAIL cycle_compare t=%0t: dut=%h model=%h", $time, dv, ev);
            end
        end
    end

    task automatic pulse(input bit p, input bit pa, input bit s, input bit r);
        @(posedge clk); #2;
        play = p; pause = pa; stop = s; rst = r;
        @(posedge clk); #2;
        play = 0; pause = 0; stop = 0; rst = 0;
    endtask

    task automatic wait_en(input logic want, input string nm);
        int i;
        i = 0;
        while (snd_en !== want && i < 300) begin @(negedge clk); i++; end
        check(nm, 32'(snd_en), 32'(want));
    endtask

    task automatic count_en(output int n);
        n = 0;
        while (snd_en === 1'b1 && n < 300) begin n++; @(negedge clk); end
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 300 && done !== 1'b1; i++) @(negedge clk);
        check(nm, 32'(done), 1);
    endtask

    initial begin
        int n, done_seen, prev;
        int q[$];
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0]   = 16'h4A40; rom[1]   = 16'h8000;
        rom[64]  = 16'h4E40; rom[65]  = 16'h8000;
        rom[128] = 16'h2C80; rom[129] = 16'h1200; rom[130] = 16'h8000;
        rom[192] = 16'h5600; rom[193] = 16'h3A40; rom[194] = 16'h8000;

        repeat (3) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        check("reset_addr", 32'(rom_addr), 0);
        check("reset_mute", 32'(snd_mute), 1);
        check("reset_en", 32'(snd_en), 0);
        check("reset_playing", 32'(playing), 0);

        // Single note then end marker.
        song_sel = 2'd0; tempo = 4'd5;
        pulse(1, 0, 0, 0);
        wait_en(1'b1, "t1_en_rise");
        check("t1_octave", 32'(snd_octave), 4);
        check("t1_note", 32'(snd_note), 5);
        check("t1_length", 32'(snd_length), 1);
        check("t1_full_note", 32'(snd_full_note), 5);
        check("t1_mute", 32'(snd_mute), 0);
        count_en(n);
        check("t1_en_cycles", n, 5);
        wait_done("t1_done");
        check("t1_done_en", 32'(snd_en), 0);

        // Rest note.
        song_sel = 2'd1;
        pulse(1, 0, 0, 0);
        wait_en(1'b1, "t2_en_rise");
        check("t2_mute", 32'(snd_mute), 1);
        check("t2_note", 32'(snd_note), 0);
        check("t2_octave", 32'(snd_octave), 4);
        count_en(n);
        check("t2_en_cycles", n, 5);
        wait_done("t2_done");

        // Looping two-note song from song 2; tempo change mid-song is ignored.
        song_sel = 2'd2; tempo = 4'd7; loop = 1'b1;
        pulse(1, 0, 0, 0);
        @(negedge clk);
        check("t3_first_addr", 32'(rom_addr), 128);
        tempo = 4'd9; song_sel = 2'd0;
        prev = int'(rom_addr); q.push_back(prev); done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
            if (int'(rom_addr) != prev) begin prev = int'(rom_addr); q.push_back(prev); end
        end
        check("t3_addr0", (q.size() > 0) ? q[0] : -1, 128);
        check("t3_addr1", (q.size() > 1) ? q[1] : -1, 129);
        check("t3_addr2", (q.size() > 2) ? q[2] : -1, 130);
        check("t3_addr3", (q.size() > 3) ? q[3] : -1, 128);
        check("t3_addr4", (q.size() > 4) ? q[4] : -1, 129);
        check("t3_done_never", done_seen, 0);
        check("t3_full_note", 32'(snd_full_note), 7);
        pulse(0, 0, 1, 0);
        loop = 1'b0;
        @(negedge clk);
        check("t3_stop_playing", 32'(playing), 0);

        // Pause mid-note, resume replays the same word; stale over during arm is ignored.
        song_sel = 2'd3; gen_n = 8;
        pulse(1, 0, 0, 0);
        wait_en(1'b1, "t4_en_rise");
        repeat (4) @(negedge clk);
        pulse(0, 1, 0, 0);
        @(negedge clk);
        check("t4_pause_en", 32'(snd_en), 0);
        check("t4_paused", 32'(paused), 1);
        gen_hold = 2;
        pulse(1, 0, 0, 0);
        wait_en(1'b1, "t4_resume_en");
        check("t4_resume_addr", 32'(rom_addr), 192);
        count_en(n);
        check("t4_en_cycles", n, 10);
        gen_hold = 1;

        // Stop and pause together on the second note.
        wait_en(1'b1, "t5_en_rise");
        repeat (2) @(negedge clk);
        pulse(0, 1, 1, 0);
        @(negedge clk);
        check("t5_playing", 32'(playing), 0);
        check("t5_paused", 32'(paused), 0);
        check("t5_en", 32'(snd_en), 0);

        // Reset in the gap.
        song_sel = 2'd0; gen_n = 3; tempo = 4'd6;
        pulse(1, 0, 0, 0);
        wait_en(1'b1, "t6_en_rise");
        count_en(n);
        pulse(0, 0, 0, 1);
        @(negedge clk);
        check("t6_addr", 32'(rom_addr), 0);
        check("t6_mute", 32'(snd_mute), 1);
        check("t6_en", 32'(snd_en), 0);
        check("t6_octave", 32'(snd_octave), 0);
        check("t6_full_note", 32'(snd_full_note), 0);
        check("t6_playing", 32'(playing), 0);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
        $fatal(1);
    end

endmodule
